// File: rtl/cache_assoc.sv
// Set-associative (1 or 2 ways), write-through, no-write-allocate cache with burst line refill and LRU.
// Optional CACHE_STATS_EN adds saturating read hit/miss counters (HitCount, MissCount).
module cache_assoc #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int INDEX_BITS  = 8,
    parameter int OFFSET_BITS = 2,
    parameter int WAYS        = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              PStrobe,
    input  logic              PRW,
    input  logic [ADDR_W-1:0] PAddress,
    input  logic [DATA_W-1:0] PDataIn,
    output logic              PReady,
    output logic [DATA_W-1:0] PDataOut,
    output logic              MStrobe,
    output logic              MRW,
    output logic [ADDR_W-1:0] MAddress,
    output logic [DATA_W-1:0] MDataIn,
    input  logic [DATA_W-1:0] MDataOut,
    input  logic              MReady,
`ifdef CACHE_STATS_EN
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount,
`endif
    output logic [2:0]        dbg_state_o
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITE, S_REFILL, S_RESP} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-3:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q, rdata_q, pdout_q;
    logic                     rw_q, hit_q, hway_q, victim_q;
    logic [OFFSET_BITS-1:0]   cnt_q;
    logic [SETS-1:0]          valid_q [WAYS];
    logic [TAG_W-1:0]         tag_mem [WAYS][SETS];
    logic [DATA_W-1:0]        data_mem [WAYS][SETS][WORDS];

    logic [TAG_W-1:0]         l_tag;
    logic [INDEX_BITS-1:0]    l_idx;
    logic [OFFSET_BITS-1:0]   l_off;
    logic                     hit, hit_way, victim, lru_way;
    logic                     rd_hit, refill_we, refill_last, write_hit_we;
    logic                     unused_bits;

    assign l_tag       = addr_q[ADDR_W-3 -: TAG_W];
    assign l_idx       = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign l_off       = addr_q[OFFSET_BITS-1:0];
    assign unused_bits = ^PAddress[1:0];
    assign dbg_state_o = state_q;

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][l_idx] && tag_mem[w][l_idx] == l_tag) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Invalid ways are filled before anything is evicted, way 0 first.
    always_comb begin
        victim = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][l_idx])           victim = 1'b0;
            else if (!valid_q[WAYS-1][l_idx]) victim = 1'b1;
            else                              victim = lru_way;
        end
    end

    assign rd_hit       = (state_q == S_LOOKUP) && rw_q && hit;
    assign refill_we    = (state_q == S_REFILL) && MReady;
    assign refill_last  = refill_we && (cnt_q == '1);
    assign write_hit_we = (state_q == S_WRITE) && MReady && hit_q;

    // Memory handshake: MStrobe and its address/data/RW hold steady until the
    // cycle in which MReady=1; that edge transfers exactly one word.
    always_comb begin
        state_d  = state_q;
        PReady   = 1'b0;
        PDataOut = pdout_q;
        MStrobe  = 1'b0;
        MRW      = 1'b1;
        MAddress = '0;
        MDataIn  = '0;
        case (state_q)
            S_IDLE:   if (PStrobe) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (!rw_q) begin
                    state_d = S_WRITE;
                end else if (hit) begin
                    PReady   = 1'b1;
                    PDataOut = data_mem[hit_way][l_idx][l_off];
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITE: begin
                MStrobe  = 1'b1;
                MRW      = 1'b0;
                MAddress = {addr_q, 2'b00};
                MDataIn  = wdata_q;
                if (MReady) state_d = S_RESP;
            end
            S_REFILL: begin
                MStrobe  = 1'b1;
                MAddress = {l_tag, l_idx, cnt_q, 2'b00};
                if (refill_last) state_d = S_RESP;
            end
            S_RESP: begin
                PReady  = 1'b1;
                if (rw_q) PDataOut = rdata_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b1;
            hit_q    <= 1'b0;
            hway_q   <= 1'b0;
            victim_q <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            pdout_q  <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && PStrobe) begin
                addr_q  <= PAddress[ADDR_W-1:2];
                wdata_q <= PDataIn;
                rw_q    <= PRW;
            end
            if (state_q == S_LOOKUP) begin
                hit_q    <= hit;
                hway_q   <= hit_way;
                victim_q <= victim;
                cnt_q    <= '0;
            end
            if (refill_we) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == l_off) rdata_q <= MDataOut;
            end
            if (refill_last) valid_q[victim_q][l_idx] <= 1'b1;
            if (PReady) pdout_q <= PDataOut;
        end
    end

    // Arrays carry no reset; a line only becomes visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (refill_we)    data_mem[victim_q][l_idx][cnt_q] <= MDataOut;
        if (write_hit_we) data_mem[hway_q][l_idx][l_off]   <= wdata_q;
        if (refill_last)  tag_mem[victim_q][l_idx]         <= l_tag;
    end

    // lru_q[set] names the least recently used way of that set.
    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q;
        always_ff @(posedge clk or negedge Reset) begin
            if (!Reset) begin
                lru_q <= '0;
            end else if (rd_hit) begin
                lru_q[l_idx] <= ~hit_way;
            end else if (write_hit_we) begin
                lru_q[l_idx] <= ~hway_q;
            end else if (refill_last) begin
                lru_q[l_idx] <= ~victim_q;
            end
        end
        assign lru_way = lru_q[l_idx];
    end else begin : g_no_lru
        assign lru_way = 1'b0;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP && rw_q) begin
            if (hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif
endmodule
